// File: rtl/sqrt_formula_dispatcher_if.sv
// Handshake bundle between a producer of argument triples and the sqrt dispatcher.
// The master drives triples and accepts results; the slave is the dispatcher.
interface sqrt_formula_dispatcher_if #(
    parameter int N_WORKERS = 4
);
    localparam int CNT_W = $clog2(N_WORKERS + 1);

    logic             arg_vld;
    logic             arg_rdy;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      c;
    logic             res_vld;
    logic             res_rdy;
    logic [31:0]      res;
    logic [CNT_W-1:0] outstanding;

    modport master (
        output arg_vld, a, b, c, res_rdy,
        input  arg_rdy, res_vld, res, outstanding
    );

    modport slave (
        input  arg_vld, a, b, c, res_rdy,
        output arg_rdy, res_vld, res, outstanding
    );
endinterface

// File: rtl/sqrt_formula_dispatcher.sv
// Pool of iterative isqrt formula workers behind an in-order dispatcher.
// Triples go to the lowest idle slot; results leave in acceptance order.

// Digit-by-digit floor square root: one result bit per cycle, 16 steps.
module sqrt_isqrt_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x,
    output logic        done,
    output logic [15:0] root
);
    logic [31:0] x_reg;
    logic [15:0] rem_reg;
    logic [15:0] root_reg;
    logic [3:0]  cnt_reg;
    logic        active_reg;
    logic        done_reg;
    logic [17:0] rem_shift;
    logic [17:0] trial;
    logic        rem_ge;

    assign rem_shift = {rem_reg, x_reg[31:30]};
    assign trial     = {root_reg, 2'b01};
    assign rem_ge    = (rem_shift >= trial);

    // The remainder fits in 16 bits before the final step; the final remainder is never used.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg      <= '0;
            rem_reg    <= '0;
            root_reg   <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                x_reg      <= x;
                rem_reg    <= '0;
                root_reg   <= '0;
                cnt_reg    <= '0;
                active_reg <= 1'b1;
            end else if (active_reg) begin
                x_reg    <= {x_reg[29:0], 2'b00};
                rem_reg  <= 16'(rem_ge ? (rem_shift - trial) : rem_shift);
                root_reg <= {root_reg[14:0], rem_ge};
                cnt_reg  <= cnt_reg + 4'd1;
                if (cnt_reg == 4'd15) begin
                    active_reg <= 1'b0;
                    done_reg   <= 1'b1;
                end
            end
        end
    end

    assign done = done_reg;
    assign root = root_reg;
endmodule

// isqrt(a)+isqrt(b)+isqrt(c) with one shared root engine used three times.
module formula_1_impl_1_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        res_vld,
    output logic [31:0] res
);
    typedef enum logic [1:0] {W_IDLE, W_SQ_A, W_SQ_B, W_SQ_C} state_t;
    state_t      state_reg, state_next;
    logic [31:0] b_reg, b_next, c_reg, c_next;
    logic [31:0] acc_reg, acc_next, res_reg, res_next;
    logic        res_vld_reg, res_vld_next;
    logic        sq_start, sq_done;
    logic [31:0] sq_x;
    logic [15:0] sq_root;

    sqrt_isqrt_unit u_sq (
        .clk(clk), .rst(rst), .start(sq_start), .x(sq_x), .done(sq_done), .root(sq_root)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= W_IDLE;
            b_reg       <= '0;
            c_reg       <= '0;
            acc_reg     <= '0;
            res_reg     <= '0;
            res_vld_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            b_reg       <= b_next;
            c_reg       <= c_next;
            acc_reg     <= acc_next;
            res_reg     <= res_next;
            res_vld_reg <= res_vld_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        b_next       = b_reg;
        c_next       = c_reg;
        acc_next     = acc_reg;
        res_next     = res_reg;
        res_vld_next = 1'b0;
        sq_start     = 1'b0;
        sq_x         = a;
        case (state_reg)
            W_IDLE: if (arg_vld) begin
                sq_start   = 1'b1;
                b_next     = b;
                c_next     = c;
                state_next = W_SQ_A;
            end
            W_SQ_A: if (sq_done) begin
                sq_start   = 1'b1;
                sq_x       = b_reg;
                acc_next   = {16'b0, sq_root};
                state_next = W_SQ_B;
            end
            W_SQ_B: if (sq_done) begin
                sq_start   = 1'b1;
                sq_x       = c_reg;
                acc_next   = acc_reg + {16'b0, sq_root};
                state_next = W_SQ_C;
            end
            default: if (sq_done) begin
                res_next     = acc_reg + {16'b0, sq_root};
                res_vld_next = 1'b1;
                state_next   = W_IDLE;
            end
        endcase
    end

    assign res_vld = res_vld_reg;
    assign res     = res_reg;
endmodule

// isqrt(a)+isqrt(b)+isqrt(c) with three root engines running side by side.
module formula_1_impl_2_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        res_vld,
    output logic [31:0] res
);
    typedef enum logic {W_IDLE, W_RUN} state_t;
    state_t      state_reg, state_next;
    logic [31:0] res_reg, res_next;
    logic        res_vld_reg, res_vld_next;
    logic        sq_start;
    logic [2:0]  sq_done;
    logic [15:0] root_a, root_b, root_c;

    sqrt_isqrt_unit u_sq_a (.clk(clk), .rst(rst), .start(sq_start), .x(a), .done(sq_done[0]), .root(root_a));
    sqrt_isqrt_unit u_sq_b (.clk(clk), .rst(rst), .start(sq_start), .x(b), .done(sq_done[1]), .root(root_b));
    sqrt_isqrt_unit u_sq_c (.clk(clk), .rst(rst), .start(sq_start), .x(c), .done(sq_done[2]), .root(root_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= W_IDLE;
            res_reg     <= '0;
            res_vld_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            res_reg     <= res_next;
            res_vld_reg <= res_vld_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        res_next     = res_reg;
        res_vld_next = 1'b0;
        sq_start     = 1'b0;
        case (state_reg)
            W_IDLE: if (arg_vld) begin
                sq_start   = 1'b1;
                state_next = W_RUN;
            end
            default: if (&sq_done) begin
                res_next     = {16'b0, root_a} + {16'b0, root_b} + {16'b0, root_c};
                res_vld_next = 1'b1;
                state_next   = W_IDLE;
            end
        endcase
    end

    assign res_vld = res_vld_reg;
    assign res     = res_reg;
endmodule

// isqrt(a+isqrt(b+isqrt(c))); the inner additions wrap modulo 2^32.
module formula_2_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        res_vld,
    output logic [31:0] res
);
    typedef enum logic [1:0] {W_IDLE, W_SQ_C, W_SQ_B, W_SQ_A} state_t;
    state_t      state_reg, state_next;
    logic [31:0] a_reg, a_next, b_reg, b_next;
    logic [31:0] res_reg, res_next;
    logic        res_vld_reg, res_vld_next;
    logic        sq_start, sq_done;
    logic [31:0] sq_x;
    logic [15:0] sq_root;

    sqrt_isqrt_unit u_sq (
        .clk(clk), .rst(rst), .start(sq_start), .x(sq_x), .done(sq_done), .root(sq_root)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= W_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            res_reg     <= '0;
            res_vld_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            res_reg     <= res_next;
            res_vld_reg <= res_vld_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        res_next     = res_reg;
        res_vld_next = 1'b0;
        sq_start     = 1'b0;
        sq_x         = c;
        case (state_reg)
            W_IDLE: if (arg_vld) begin
                sq_start   = 1'b1;
                a_next     = a;
                b_next     = b;
                state_next = W_SQ_C;
            end
            W_SQ_C: if (sq_done) begin
                sq_start   = 1'b1;
                sq_x       = b_reg + {16'b0, sq_root};
                state_next = W_SQ_B;
            end
            W_SQ_B: if (sq_done) begin
                sq_start   = 1'b1;
                sq_x       = a_reg + {16'b0, sq_root};
                state_next = W_SQ_A;
            end
            default: if (sq_done) begin
                res_next     = {16'b0, sq_root};
                res_vld_next = 1'b1;
                state_next   = W_IDLE;
            end
        endcase
    end

    assign res_vld = res_vld_reg;
    assign res     = res_reg;
endmodule

module sqrt_formula_dispatcher #(
    parameter int formula   = 1,
    parameter int impl      = 1,
    parameter int N_WORKERS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    sqrt_formula_dispatcher_if.slave  bus
);
    localparam int SLOT_W = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
    localparam int CNT_W  = $clog2(N_WORKERS + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} slot_state_t;

    logic [N_WORKERS-1:0] idle_vec;
    logic [N_WORKERS-1:0] done_vec;
    logic [31:0]          hold_arr [N_WORKERS];
    logic [SLOT_W-1:0]    alloc_idx;
    logic [SLOT_W-1:0]    fifo_mem [N_WORKERS];
    logic [SLOT_W-1:0]    wr_ptr_reg, rd_ptr_reg, head_idx;
    logic [CNT_W-1:0]     count_reg;
    logic                 arg_rdy, res_vld, accept, deliver;

    function automatic logic [SLOT_W-1:0] ptr_inc(input logic [SLOT_W-1:0] p);
        return (p == SLOT_W'(N_WORKERS - 1)) ? '0 : p + SLOT_W'(1);
    endfunction

    // Lowest-index idle slot wins; scanning downward leaves the smallest match.
    always_comb begin
        alloc_idx = '0;
        for (int i = N_WORKERS - 1; i >= 0; i--) begin
            if (idle_vec[i]) alloc_idx = SLOT_W'(i);
        end
    end

    assign arg_rdy  = |idle_vec;
    assign accept   = bus.arg_vld & arg_rdy;
    assign head_idx = fifo_mem[rd_ptr_reg];
    assign res_vld  = (count_reg != '0) && done_vec[head_idx];
    assign deliver  = res_vld & bus.res_rdy;

    assign bus.arg_rdy     = arg_rdy;
    assign bus.res_vld     = res_vld;
    assign bus.res         = res_vld ? hold_arr[head_idx] : '0;
    assign bus.outstanding = count_reg;

    // Order FIFO of slot indices; occupancy is bounded by the slot count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < N_WORKERS; i++) fifo_mem[i] <= '0;
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr_reg] <= alloc_idx;
                wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
            end
            if (deliver) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({accept, deliver})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    for (genvar gi = 0; gi < N_WORKERS; gi++) begin : g_slot
        slot_state_t state_reg;
        logic [31:0] hold_reg, a_reg, b_reg, c_reg;
        logic        launch_reg;
        logic        w_res_vld;
        logic [31:0] w_res;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_reg  <= S_IDLE;
                hold_reg   <= '0;
                a_reg      <= '0;
                b_reg      <= '0;
                c_reg      <= '0;
                launch_reg <= 1'b0;
            end else begin
                launch_reg <= 1'b0;
                case (state_reg)
                    S_IDLE: if (accept && alloc_idx == SLOT_W'(gi)) begin
                        state_reg  <= S_BUSY;
                        a_reg      <= bus.a;
                        b_reg      <= bus.b;
                        c_reg      <= bus.c;
                        launch_reg <= 1'b1;
                    end
                    S_BUSY: if (w_res_vld) begin
                        hold_reg  <= w_res;
                        state_reg <= S_DONE;
                    end
                    S_DONE: if (deliver && head_idx == SLOT_W'(gi)) begin
                        state_reg <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end

        assign idle_vec[gi] = (state_reg == S_IDLE);
        assign done_vec[gi] = (state_reg == S_DONE);
        assign hold_arr[gi] = hold_reg;

        if (formula == 2) begin : g_f2
            formula_2_top u_worker (
                .clk(clk), .rst(rst), .arg_vld(launch_reg), .a(a_reg), .b(b_reg), .c(c_reg),
                .res_vld(w_res_vld), .res(w_res)
            );
        end else if (impl == 2) begin : g_f1_i2
            formula_1_impl_2_top u_worker (
                .clk(clk), .rst(rst), .arg_vld(launch_reg), .a(a_reg), .b(b_reg), .c(c_reg),
                .res_vld(w_res_vld), .res(w_res)
            );
        end else begin : g_f1_i1
            formula_1_impl_1_top u_worker (
                .clk(clk), .rst(rst), .arg_vld(launch_reg), .a(a_reg), .b(b_reg), .c(c_reg),
                .res_vld(w_res_vld), .res(w_res)
            );
        end
    end
endmodule

// File: doc/sqrt_formula_dispatcher.md
SQRT_FORMULA_DISPATCHER -- requirements
Module: sqrt_formula_dispatcher

Interface
REQ-001 SHALL have parameter formula, default 1: 1 = isqrt(a)+isqrt(b)+isqrt(c); 2 = isqrt(a+isqrt(b+isqrt(c))).
REQ-002 SHALL have parameter impl, default 1: worker variant for formula 1 (1 = formula_1_impl_1_top, 2 = formula_1_impl_2_top); ignored for formula 2 (formula_2_top).
REQ-003 SHALL have parameter N_WORKERS, default 4: number of FSM worker instances, legal range 1..64.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 arg_vld  input  1  argument triple valid.
REQ-007 arg_rdy  output  1  dispatcher can accept a triple this cycle.
REQ-008 a, b, c  input  32 each  unsigned arguments.
REQ-009 res_vld  output  1  result valid.
REQ-010 res_rdy  input  1  downstream accepts result.
REQ-011 res  output  32  result, meaningful only while res_vld=1.
REQ-012 outstanding  output  $clog2(N_WORKERS+1)  triples accepted but not yet delivered.

Function
REQ-013 Each worker slot SHALL hold state IDLE, BUSY or DONE, plus a 32-bit result holding register.
REQ-014 arg_rdy SHALL be 1 iff at least one slot is IDLE; it SHALL depend only on registered state, never on arg_vld or res_rdy.
REQ-015 Accept occurs when arg_vld & arg_rdy; the lowest-index IDLE slot SHALL be allocated and go IDLE->BUSY.
REQ-016 On accept, a/b/c SHALL be registered for that slot; the slot's worker arg_vld SHALL pulse high for exactly one cycle, the cycle after accept.
REQ-017 arg_vld while arg_rdy=0 SHALL be ignored; no state changes and the triple is not stored.
REQ-018 Worker res_vld pulse SHALL capture worker res into the slot holding register and move BUSY->DONE on the same edge; several workers finishing in one cycle SHALL all be captured.
REQ-019 Worker res_vld for a slot not in BUSY SHALL be ignored.
REQ-020 Accepted slot indices SHALL be pushed into an order FIFO of depth N_WORKERS; results SHALL be delivered strictly in acceptance order.
REQ-021 res_vld SHALL be 1 iff FIFO non-empty and head slot is DONE; res SHALL equal that slot's holding register.
REQ-022 On res_vld & res_rdy: pop FIFO, head slot DONE->IDLE; the freed slot becomes allocatable the following cycle (not same cycle).
REQ-023 While res_vld=1 and res_rdy=0, res SHALL stay stable; younger DONE slots SHALL wait.
REQ-024 Same-cycle accept and delivery SHALL both occur (FIFO push and pop together); outstanding unchanged.
REQ-025 outstanding SHALL increment on accept, decrement on delivery, and equal the FIFO occupancy; FIFO cannot overflow because occupancy never exceeds N_WORKERS.
REQ-026 Minimum latency from accept to res_vld SHALL be worker latency + 2 cycles: one cycle for the launch pulse, one for capture.
REQ-027 Sustained throughput SHALL be N_WORKERS triples per (worker latency + 3) cycles; with N_WORKERS >= latency+3 and res_rdy=1, arg_rdy SHALL stay 1.
REQ-028 All arithmetic SHALL be unsigned and floor-isqrt, as produced by the workers; no saturation logic in the dispatcher.

Reset
REQ-029 rst SHALL drive all slots to IDLE, empty the FIFO and clear holding registers; it SHALL also reset all worker instances.
REQ-030 During and after rst: arg_rdy=1 (first cycle after rst deasserts), res_vld=0, res=0, outstanding=0.
REQ-031 rst mid-operation SHALL discard all in-flight work; no stale result SHALL appear after reset.

Verification
REQ-032 formula=1, single triple a=1,b=4,c=9, res_rdy=1 -> exactly one res_vld pulse, res=6, outstanding back to 0.
REQ-033 formula=2, triple a=6,b=5,c=16 -> res=3; formula=1, a=b=c=0xFFFFFFFF -> res=196605.
REQ-034 N_WORKERS=4, arg_vld held 1 with triples (0,0,k*k), k=1..6 -> arg_rdy drops after 4 accepts; results 1..6 delivered in order, none lost or duplicated.
REQ-035 res_rdy=0 for 100 cycles with 4 triples outstanding -> res_vld=1 with res stable on the first result, arg_rdy=0; release res_rdy -> four results in order on consecutive cycles.
REQ-036 rst asserted while 3 triples are BUSY -> next cycle outstanding=0, res_vld=0; a new triple a=1,b=1,c=1 (formula 1) -> res=3 only.
REQ-037 Random arg_vld/res_rdy over 10k triples against a reference model -> in-order match, outstanding never > N_WORKERS.
